// File: rtl/dg0045_cycle_sequencer_if.sv
// rtl/dg0045_cycle_sequencer_if.sv - control/fetch bundle for the cycle sequencer (step pin under DG0045_SINGLE_STEP_EN)
interface dg0045_cycle_sequencer_if #(
    parameter int PC_W = 6
);
    logic            ena;
    logic [7:0]      rom_data;
    logic            jump_req;
    logic            call_req;
    logic            ret_req;
    logic            skip_req;
    logic [PC_W-1:0] jump_addr;
`ifdef DG0045_SINGLE_STEP_EN
    logic            step;
`endif
    logic [PC_W-1:0] pc;
    logic [2:0]      phase;
    logic            cycle_end;
    logic [7:0]      ir;
    logic            ir_valid;
    logic            stack_err;

    modport master (
`ifdef DG0045_SINGLE_STEP_EN
        output step,
`endif
        output ena, rom_data, jump_req, call_req, ret_req, skip_req, jump_addr,
        input  pc, phase, cycle_end, ir, ir_valid, stack_err
    );

    modport slave (
`ifdef DG0045_SINGLE_STEP_EN
        input  step,
`endif
        input  ena, rom_data, jump_req, call_req, ret_req, skip_req, jump_addr,
        output pc, phase, cycle_end, ir, ir_valid, stack_err
    );
endinterface

// File: rtl/dg0045_cycle_sequencer.sv
// rtl/dg0045_cycle_sequencer.sv - 8-phase machine-cycle sequencer, PC and return stack (single-step via DG0045_SINGLE_STEP_EN)
module dg0045_cycle_sequencer #(
    parameter int PC_W        = 6,
    parameter int STACK_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dg0045_cycle_sequencer_if.slave    bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [2:0]      phase_q;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q;
    logic            ir_valid_q;
    logic            stack_err_q, stack_err_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [PC_W-1:0] stack_d [STACK_DEPTH];
    logic [PC_W-1:0] pc_inc;
    logic            conflict;
    logic            adv;

    assign pc_inc   = pc_q + PC_W'(1);
    assign conflict = (bus.call_req & bus.jump_req) | (bus.call_req & bus.ret_req) |
                      (bus.jump_req & bus.ret_req);

    // In single-step mode the machine parks at phase 0 until a step pulse arrives.
`ifdef DG0045_SINGLE_STEP_EN
    assign adv = bus.ena && ((phase_q != 3'd0) || bus.step);
`else
    assign adv = bus.ena;
`endif

    // End-of-cycle PC/stack resolution; only committed on the enabled phase-7 edge.
    always_comb begin
        pc_d        = pc_inc;
        sp_d        = sp_q;
        stack_d     = stack_q;
        stack_err_d = stack_err_q | conflict;
        if (bus.call_req) begin
            pc_d = bus.jump_addr;
            if (int'(sp_q) == STACK_DEPTH) begin
                // Full: drop the oldest entry, shift down and push on top.
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[STACK_DEPTH-1] = pc_inc;
                stack_err_d            = 1'b1;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (i == int'(sp_q)) begin
                        stack_d[i] = pc_inc;
                    end
                end
                sp_d = sp_q + 1'b1;
            end
        end else if (bus.jump_req) begin
            pc_d = bus.jump_addr;
        end else if (bus.ret_req) begin
            if (sp_q == '0) begin
                pc_d        = '0;
                stack_err_d = 1'b1;
            end else begin
                pc_d = '0;
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (i + 1 == int'(sp_q)) begin
                        pc_d = stack_q[i];
                    end
                end
                sp_d = sp_q - 1'b1;
            end
        end else if (bus.skip_req) begin
            pc_d = pc_q + PC_W'(2);
        end
    end

    // Phase counter, instruction fetch and end-of-cycle state update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= 3'd0;
            pc_q        <= '0;
            ir_q        <= 8'h00;
            ir_valid_q  <= 1'b0;
            stack_err_q <= 1'b0;
            sp_q        <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (adv) begin
            phase_q <= phase_q + 3'd1;
            if (phase_q == 3'd3) begin
                ir_q       <= bus.rom_data;
                ir_valid_q <= 1'b1;
            end
            if (phase_q == 3'd7) begin
                ir_valid_q  <= 1'b0;
                pc_q        <= pc_d;
                sp_q        <= sp_d;
                stack_q     <= stack_d;
                stack_err_q <= stack_err_d;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.phase     = phase_q;
    assign bus.cycle_end = (phase_q == 3'd7);
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.stack_err = stack_err_q;
endmodule
